// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // MemRead / MemWr field encodings; anything non-zero is an access
  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_BYTE = 2'd1;
  localparam logic [1:0] MEM_HALF = 2'd2;
  localparam logic [1:0] MEM_WORD = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Per-stage enable / flush bundle driven to the pipeline registers
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_OFF    = stage_ctl_t'(7'b0000000);
  localparam stage_ctl_t CTL_FREEZE = stage_ctl_t'(7'b0000001);
  localparam stage_ctl_t CTL_ADV    = stage_ctl_t'(7'b1101010);
  localparam stage_ctl_t CTL_BR     = stage_ctl_t'(7'b1111110);
  localparam stage_ctl_t CTL_LU     = stage_ctl_t'(7'b0001110);

  // Control for a cycle with no memory stall: branch squash beats load-use bubble
  function automatic stage_ctl_t advance_ctl(input logic br_taken, input logic lu);
    if (br_taken)  return CTL_BR;
    else if (lu)   return CTL_LU;
    else           return CTL_ADV;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the performance-debug counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  // Count up on inc, stick at all-ones, never wrap
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                  q <= '0;
    else if (clear)              q <= '0;
    else if (inc && (q != '1))   q <= q + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// taken-branch squashes and variable-latency data-memory handshakes.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       id_Rs,
  input  logic [4:0]       id_Rt,
  input  logic             id_UseRt,
  input  logic [1:0]       ex_MemRead,
  input  logic [4:0]       ex_Rw,
  input  logic             ex_BrTaken,
  input  logic [1:0]       mem_MemRead,
  input  logic [1:0]       mem_MemWr,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_q;
  logic            mem_acc, lu, wait_last;
  stage_ctl_t      ctl;
  logic            req, err_set, br_evt, stall_evt;

  assign mem_acc   = (mem_MemRead != MEM_NONE) | (mem_MemWr != MEM_NONE);
  assign lu        = (ex_MemRead != MEM_NONE) & (ex_Rw != REG_ZERO) &
                     ((ex_Rw == id_Rs) | (id_UseRt & (ex_Rw == id_Rt)));
  assign wait_last = (wait_q == WC_LAST);

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state: enter MEM_WAIT on an un-acked access, leave on ack or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_acc && !mem_ack)   state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ack || wait_last)  state_d = RUN;
      default:                             state_d = RUN;
    endcase
  end

  // Wait counter: idle at 0 in RUN, counts un-acked MEM_WAIT cycles
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                          wait_q <= '0;
    else if (state_q == RUN)             wait_q <= '0;
    else if (!mem_ack && !wait_last)     wait_q <= wait_q + 1'b1;
  end

  // Outputs: stage controls, request and event strobes; all dead while in reset
  always_comb begin
    ctl     = CTL_OFF;
    req     = 1'b0;
    err_set = 1'b0;
    br_evt  = 1'b0;
    case (state_q)
      RUN: begin
        req = mem_acc;
        if (mem_acc && !mem_ack) begin
          ctl = CTL_FREEZE;
        end else begin
          ctl    = advance_ctl(ex_BrTaken, lu);
          br_evt = ex_BrTaken;
        end
      end
      MEM_WAIT: begin
        req = 1'b1;
        if (mem_ack) begin
          ctl    = advance_ctl(ex_BrTaken, lu);
          br_evt = ex_BrTaken;
        end else if (wait_last) begin
          // abort: move on, but drop the load result that never arrived
          ctl              = advance_ctl(ex_BrTaken, lu);
          ctl.mem_wb_flush = 1'b1;
          br_evt           = ex_BrTaken;
          err_set          = 1'b1;
        end else begin
          ctl = CTL_FREEZE;
        end
      end
      default: ctl = CTL_OFF;
    endcase
    if (!Rst_n) begin
      ctl     = CTL_OFF;
      req     = 1'b0;
      err_set = 1'b0;
      br_evt  = 1'b0;
    end
  end

  assign pc_en        = ctl.pc_en;
  assign if_id_en     = ctl.if_id_en;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_en     = ctl.id_ex_en;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_en    = ctl.ex_mem_en;
  assign mem_wb_flush = ctl.mem_wb_flush;
  assign mem_req      = req;

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)       mem_err <= 1'b0;
    else if (err_set) mem_err <= 1'b1;
  end

  assign stall_evt = Rst_n & ~ctl.pc_en;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (stall_evt),
    .clear (1'b0),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (br_evt),
    .clear (1'b0),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (small TIMEOUT / CNT_W to reach boundaries).
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [4:0] id_Rs, id_Rt, ex_Rw;
  logic       id_UseRt, ex_BrTaken, mem_ack;
  logic [1:0] ex_MemRead, mem_MemRead, mem_MemWr;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic       mem_req, mem_err;
  logic [3:0] stall_cnt, flush_cnt;

  int errs   = 0;
  int checks = 0;

  // {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_flush}
  localparam logic [6:0] C_OFF = 7'b0000000;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_ADV = 7'b1101010;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_LU  = 7'b0001110;
  localparam logic [6:0] C_ABT = 7'b1101011;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .id_Rs(id_Rs), .id_Rt(id_Rt), .id_UseRt(id_UseRt),
    .ex_MemRead(ex_MemRead), .ex_Rw(ex_Rw), .ex_BrTaken(ex_BrTaken),
    .mem_MemRead(mem_MemRead), .mem_MemWr(mem_MemWr), .mem_ack(mem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_flush(mem_wb_flush), .mem_req(mem_req), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 Clk = ~Clk;

  wire [6:0] ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_Rs = 0; id_Rt = 0; id_UseRt = 0; ex_MemRead = 0; ex_Rw = 0;
    ex_BrTaken = 0; mem_MemRead = 0; mem_MemWr = 0; mem_ack = 0;
  endtask

  // advance one clock; land just after the edge
  task automatic tick();
    @(posedge Clk); #1;
  endtask

  initial begin
    idle();
    Rst_n = 1'b0;
    #1;
    chk("rst_ctl", 16'(ctl), 16'(C_OFF));
    chk("rst_req", 16'(mem_req), 16'd0);
    ex_BrTaken = 1; mem_MemWr = 1;
    #1;
    chk("rst_ctl_forced", 16'(ctl), 16'(C_OFF));
    chk("rst_req_forced", 16'(mem_req), 16'd0);
    idle();
    tick(); tick();
    chk("rst_stall", 16'(stall_cnt), 16'd0);
    chk("rst_flush", 16'(flush_cnt), 16'd0);
    chk("rst_err", 16'(mem_err), 16'd0);
    Rst_n = 1'b1;
    #1;
    chk("idle_ctl", 16'(ctl), 16'(C_ADV));

    // load-use on rs: one bubble
    ex_MemRead = 1; ex_Rw = 5; id_Rs = 5; #1;
    chk("lu_rs_ctl", 16'(ctl), 16'(C_LU));
    tick(); idle(); #1;
    chk("lu_rs_stall", 16'(stall_cnt), 16'd1);
    chk("lu_after_ctl", 16'(ctl), 16'(C_ADV));
    // same match but destination is r0
    ex_MemRead = 1; ex_Rw = 0; id_Rs = 0; #1;
    chk("lu_r0_ctl", 16'(ctl), 16'(C_ADV));
    tick(); idle();
    chk("lu_r0_stall", 16'(stall_cnt), 16'd1);
    // rt match only counts when rt is a source
    ex_MemRead = 2; ex_Rw = 7; id_Rs = 3; id_Rt = 7; id_UseRt = 0; #1;
    chk("lu_rt_unused", 16'(ctl), 16'(C_ADV));
    id_UseRt = 1; #1;
    chk("lu_rt_ctl", 16'(ctl), 16'(C_LU));
    tick(); idle();
    chk("lu_rt_stall", 16'(stall_cnt), 16'd2);
    // not a load in EX
    ex_MemRead = 0; ex_Rw = 5; id_Rs = 5; #1;
    chk("lu_noload", 16'(ctl), 16'(C_ADV));
    tick(); idle();

    // branch overrides load-use
    ex_MemRead = 1; ex_Rw = 5; id_Rs = 5; ex_BrTaken = 1; #1;
    chk("br_ctl", 16'(ctl), 16'(C_BR));
    tick(); idle();
    chk("br_flush", 16'(flush_cnt), 16'd1);
    chk("br_stall", 16'(stall_cnt), 16'd2);

    // store with ack after 3 frozen cycles
    mem_MemWr = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("st_frz%0d_ctl", i), 16'(ctl), 16'(C_FRZ));
      chk($sformatf("st_frz%0d_req", i), 16'(mem_req), 16'd1);
      tick();
    end
    mem_ack = 1; #1;
    chk("st_ack_ctl", 16'(ctl), 16'(C_ADV));
    chk("st_ack_req", 16'(mem_req), 16'd1);
    tick(); idle();
    chk("st_stall", 16'(stall_cnt), 16'd5);
    // zero-wait load
    mem_MemRead = 3; mem_ack = 1; #1;
    chk("zw_ctl", 16'(ctl), 16'(C_ADV));
    chk("zw_req", 16'(mem_req), 16'd1);
    tick(); idle(); #1;
    chk("zw_stall", 16'(stall_cnt), 16'd5);
    chk("zw_idle_req", 16'(mem_req), 16'd0);

    // timeout abort: 4 frozen cycles, then advance with MEM/WB bubble
    mem_MemRead = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_frz%0d_ctl", i), 16'(ctl), 16'(C_FRZ));
      tick();
    end
    #1;
    chk("to_abort_ctl", 16'(ctl), 16'(C_ABT));
    chk("to_abort_req", 16'(mem_req), 16'd1);
    chk("to_err_pre", 16'(mem_err), 16'd0);
    tick(); idle(); #1;
    chk("to_err", 16'(mem_err), 16'd1);
    chk("to_stall", 16'(stall_cnt), 16'd9);
    chk("to_back_run", 16'(mem_req), 16'd0);
    tick();
    chk("to_err_sticky", 16'(mem_err), 16'd1);

    // reset in the middle of MEM_WAIT
    mem_MemWr = 1; tick(); mem_MemWr = 0; #1;
    chk("mw_req", 16'(mem_req), 16'd1);
    Rst_n = 1'b0; #1;
    chk("mwrst_req", 16'(mem_req), 16'd0);
    chk("mwrst_ctl", 16'(ctl), 16'(C_OFF));
    chk("mwrst_err", 16'(mem_err), 16'd0);
    tick();
    Rst_n = 1'b1; #1;
    chk("mwrel_req", 16'(mem_req), 16'd0);
    chk("mwrel_ctl", 16'(ctl), 16'(C_ADV));
    chk("mwrel_stall", 16'(stall_cnt), 16'd0);
    chk("mwrel_flush", 16'(flush_cnt), 16'd0);

    // saturation of both counters
    ex_MemRead = 1; ex_Rw = 9; id_Rs = 9;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("sat_stall14", 16'(stall_cnt), 16'd14);
    end
    chk("sat_stall", 16'(stall_cnt), 16'd15);
    idle(); ex_BrTaken = 1;
    for (int i = 1; i <= 20; i++) tick();
    chk("sat_flush", 16'(flush_cnt), 16'd15);
    chk("sat_stall_hold", 16'(stall_cnt), 16'd15);
    idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
